// File: rtl/ni_axi_pkt_initiator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ravenoc_pkg
//  Brief    : NoC-wide widths, AXI channel structs and the packet-initiator FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package ravenoc_pkg;

    localparam int XWidth        = 2;
    localparam int YWidth        = 2;
    localparam int PktWidth      = 8;
    localparam int NumVirtChn    = 3;
    localparam int FlitDataWidth = 32;
    localparam int VcWidth       = $clog2(NumVirtChn);

    localparam int AxiAddrWidth  = 32;
    localparam int AxiDataWidth  = FlitDataWidth;
    localparam int AxiIdWidth    = 1;
    localparam int AxiUserWidth  = 1;

    localparam logic [1:0] AXI_OKAY       = 2'b00;
    localparam logic [1:0] AXI_SLVERR     = 2'b10;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef struct packed {
        logic [XWidth-1:0]   x_dest;
        logic [YWidth-1:0]   y_dest;
        logic [PktWidth-1:0] pkt_width;
    } s_flit_head_data_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]     aw_id;
        logic [AxiAddrWidth-1:0]   aw_addr;
        logic [7:0]                aw_len;
        logic [2:0]                aw_size;
        logic [1:0]                aw_burst;
        logic                      aw_lock;
        logic [3:0]                aw_cache;
        logic [2:0]                aw_prot;
        logic [3:0]                aw_qos;
        logic [3:0]                aw_region;
        logic [AxiUserWidth-1:0]   aw_user;
        logic                      aw_valid;
        logic [AxiDataWidth-1:0]   w_data;
        logic [AxiDataWidth/8-1:0] w_strb;
        logic                      w_last;
        logic [AxiUserWidth-1:0]   w_user;
        logic                      w_valid;
        logic                      b_ready;
        logic [AxiIdWidth-1:0]     ar_id;
        logic [AxiAddrWidth-1:0]   ar_addr;
        logic [7:0]                ar_len;
        logic [2:0]                ar_size;
        logic [1:0]                ar_burst;
        logic                      ar_valid;
        logic                      r_ready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic                      aw_ready;
        logic                      w_ready;
        logic [AxiIdWidth-1:0]     b_id;
        logic [1:0]                b_resp;
        logic [AxiUserWidth-1:0]   b_user;
        logic                      b_valid;
        logic                      ar_ready;
        logic [AxiIdWidth-1:0]     r_id;
        logic [AxiDataWidth-1:0]   r_data;
        logic [1:0]                r_resp;
        logic                      r_last;
        logic [AxiUserWidth-1:0]   r_user;
        logic                      r_valid;
    } s_axi_miso_t;

    typedef enum logic [1:0] {
        INIT_IDLE = 2'd0,
        INIT_AW   = 2'd1,
        INIT_W    = 2'd2,
        INIT_B    = 2'd3
    } init_st_t;

    function automatic logic [2:0] axi_size(input int bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ni_axi_pkt_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module   : ni_axi_pkt_initiator_if
//  Brief    : AXI4 master/slave channel bundle between the PE initiator and the NI.
//  Revision : 1.0  initial release
// ============================================================================
interface ni_axi_pkt_initiator_if;
    import ravenoc_pkg::*;

    s_axi_mosi_t axi_mosi_if_o;
    s_axi_miso_t axi_miso_if_i;

    modport master (output axi_mosi_if_o, input axi_miso_if_i);
    modport slave  (input axi_mosi_if_o, output axi_miso_if_i);

endinterface
`default_nettype wire

// File: rtl/ni_axi_pkt_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : ni_axi_pkt_initiator
//  Brief    : Issues one AXI4 INCR write burst (header + payload) per packet command
//             into the selected VC write buffer of the NI and collects the B response.
//  Revision : 1.0  initial release
// ============================================================================
module ni_axi_pkt_initiator
    import ravenoc_pkg::*;
#(
    parameter logic [AxiAddrWidth-1:0] WR_BASE_ADDR = 'h1000,
    parameter logic [AxiAddrWidth-1:0] VC_STRIDE    = 'h8,
    parameter int                      B_TIMEOUT    = 1024
) (
    input  wire logic                     clk_axi,
    input  wire logic                     arst_axi,
    input  wire logic                     cmd_valid_i,
    output logic                          cmd_ready_o,
    input  wire logic [VcWidth-1:0]       cmd_vc_i,
    input  wire logic [XWidth-1:0]        cmd_x_dest_i,
    input  wire logic [YWidth-1:0]        cmd_y_dest_i,
    input  wire logic [PktWidth-1:0]      cmd_len_i,
    input  wire logic                     data_valid_i,
    output logic                          data_ready_o,
    input  wire logic [FlitDataWidth-1:0] data_i,
    ni_axi_pkt_initiator_if.master        axi_if,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o
);

    localparam int                c_TO_W    = (B_TIMEOUT > 1) ? $clog2(B_TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(B_TIMEOUT - 1);

    init_st_t            r_state, w_state_nxt;
    logic [VcWidth-1:0]  r_vc;
    logic [XWidth-1:0]   r_x;
    logic [YWidth-1:0]   r_y;
    logic [PktWidth-1:0] r_len;
    logic [PktWidth:0]   r_beat, w_beat_nxt;
    logic [c_TO_W-1:0]   r_to_cnt, w_to_nxt;
    logic                r_drain, w_drain_nxt;
    logic                r_done, w_done_nxt;
    logic                r_err, w_err_nxt;
    logic                r_alive;
    logic                w_cmd_fire;
    logic                w_last_beat;
    s_flit_head_data_t   w_head;
    s_axi_mosi_t         w_mosi;

    assign axi_if.axi_mosi_if_o = w_mosi;
    assign busy_o = (r_state != INIT_IDLE);
    assign done_o = r_done;
    assign err_o  = r_err;

    always_comb begin
        w_state_nxt  = r_state;
        w_beat_nxt   = r_beat;
        w_to_nxt     = '0;
        w_drain_nxt  = r_drain;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_cmd_fire   = 1'b0;
        cmd_ready_o  = 1'b0;
        data_ready_o = 1'b0;
        w_mosi       = '0;
        w_head           = '0;
        w_head.x_dest    = r_x;
        w_head.y_dest    = r_y;
        w_head.pkt_width = r_len;
        w_last_beat  = (r_beat == {1'b0, r_len});

        case (r_state)
            INIT_IDLE: begin
                // r_alive keeps cmd_ready low while reset is held
                cmd_ready_o    = r_alive;
                // a B response that arrives after a timeout is accepted and dropped here
                w_mosi.b_ready = r_drain;
                if (r_drain && axi_if.axi_miso_if_i.b_valid) begin
                    w_drain_nxt = 1'b0;
                end
                if (cmd_valid_i && r_alive) begin
                    w_cmd_fire  = 1'b1;
                    w_beat_nxt  = '0;
                    w_state_nxt = INIT_AW;
                end
            end
            INIT_AW: begin
                w_mosi.aw_valid = 1'b1;
                w_mosi.aw_addr  = WR_BASE_ADDR + AxiAddrWidth'(r_vc) * VC_STRIDE;
                w_mosi.aw_len   = 8'(r_len);
                w_mosi.aw_size  = axi_size(AxiDataWidth / 8);
                w_mosi.aw_burst = AXI_BURST_INCR;
                if (axi_if.axi_miso_if_i.aw_ready) begin
                    w_state_nxt = INIT_W;
                end
            end
            INIT_W: begin
                w_mosi.w_strb = '1;
                w_mosi.w_last = w_last_beat;
                if (r_beat == '0) begin
                    w_mosi.w_valid = 1'b1;
                    w_mosi.w_data  = AxiDataWidth'(w_head);
                end else begin
                    w_mosi.w_valid = data_valid_i;
                    w_mosi.w_data  = data_i;
                    data_ready_o   = axi_if.axi_miso_if_i.w_ready;
                end
                if (w_mosi.w_valid && axi_if.axi_miso_if_i.w_ready) begin
                    w_beat_nxt = r_beat + 1'b1;
                    if (w_last_beat) begin
                        w_state_nxt = INIT_B;
                    end
                end
            end
            INIT_B: begin
                w_mosi.b_ready = 1'b1;
                if (axi_if.axi_miso_if_i.b_valid) begin
                    w_done_nxt  = (axi_if.axi_miso_if_i.b_resp == AXI_OKAY);
                    w_err_nxt   = (axi_if.axi_miso_if_i.b_resp != AXI_OKAY);
                    w_state_nxt = INIT_IDLE;
                end else if ((B_TIMEOUT != 0) && (r_to_cnt == c_TO_LAST)) begin
                    w_err_nxt   = 1'b1;
                    w_drain_nxt = 1'b1;
                    w_state_nxt = INIT_IDLE;
                end else if (B_TIMEOUT != 0) begin
                    w_to_nxt = r_to_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = INIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_axi or posedge arst_axi) begin
        if (arst_axi) begin
            r_state  <= INIT_IDLE;
            r_beat   <= '0;
            r_to_cnt <= '0;
            r_drain  <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_alive  <= 1'b0;
            r_vc     <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_len    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_beat   <= w_beat_nxt;
            r_to_cnt <= w_to_nxt;
            r_drain  <= w_drain_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_alive  <= 1'b1;
            if (w_cmd_fire) begin
                r_vc  <= cmd_vc_i;
                r_x   <= cmd_x_dest_i;
                r_y   <= cmd_y_dest_i;
                r_len <= cmd_len_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ni_axi_pkt_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ni_axi_pkt_initiator
//  Brief    : Self-checking bench for ni_axi_pkt_initiator (vector table + corner sequences).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ni_axi_pkt_initiator;
    import ravenoc_pkg::*;

    logic                     clk_axi = 1'b0;
    logic                     arst_axi;
    logic                     cmd_valid_i;
    logic                     cmd_ready_o;
    logic [VcWidth-1:0]       cmd_vc_i;
    logic [XWidth-1:0]        cmd_x_dest_i;
    logic [YWidth-1:0]        cmd_y_dest_i;
    logic [PktWidth-1:0]      cmd_len_i;
    logic                     data_valid_i;
    logic                     data_ready_o;
    logic [FlitDataWidth-1:0] data_i;
    logic                     busy_o, done_o, err_o;

    logic                     aw_ready, w_ready, b_valid;
    logic [1:0]               b_resp;
    s_axi_miso_t              tb_miso;
    s_axi_mosi_t              mosi;

    always #5 clk_axi = ~clk_axi;

    ni_axi_pkt_initiator_if axi_if ();

    always_comb begin
        tb_miso          = '0;
        tb_miso.aw_ready = aw_ready;
        tb_miso.w_ready  = w_ready;
        tb_miso.b_valid  = b_valid;
        tb_miso.b_resp   = b_resp;
    end
    assign axi_if.axi_miso_if_i = tb_miso;
    assign mosi = axi_if.axi_mosi_if_o;

    ni_axi_pkt_initiator #(
        .WR_BASE_ADDR ('h1000),
        .VC_STRIDE    ('h8),
        .B_TIMEOUT    (16)
    ) dut (
        .clk_axi      (clk_axi),
        .arst_axi     (arst_axi),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_vc_i     (cmd_vc_i),
        .cmd_x_dest_i (cmd_x_dest_i),
        .cmd_y_dest_i (cmd_y_dest_i),
        .cmd_len_i    (cmd_len_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .data_i       (data_i),
        .axi_if       (axi_if.master),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    typedef struct packed { logic [31:0] data; logic last; } wbeat_t;
    typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_t;
    typedef struct {
        logic [1:0]  vc;
        logic [1:0]  x;
        logic [1:0]  y;
        logic [7:0]  len;
        logic [1:0]  resp;
        int          b_delay;
        bit          gap;
        bit          toggle;
        int          aw_stall;
        logic [31:0] exp_addr;
        bit          exp_done;
    } vec_t;

    wbeat_t      exp_w[$];
    aw_t         exp_aw[$];
    logic [31:0] feed_q[$];
    bit          gap_en, wr_toggle;
    bit          xfer_d, aw_seen;
    int          pay_cnt, dr_cnt;
    int          n_tests, n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not expected / bound expired", name);
    endtask

    // Scoreboard: AXI handshakes are sampled on the falling edge, completing on the next rise
    always @(negedge clk_axi) begin
        if (arst_axi) begin
            aw_seen = 1'b0;
            xfer_d  = 1'b0;
        end else begin
            if (mosi.w_valid && w_ready) begin
                check("w_after_aw", aw_seen, 1);
                if (exp_w.size() == 0) begin
                    fail_evt("w_extra_beat");
                end else begin
                    wbeat_t b;
                    b = exp_w.pop_front();
                    check("w_data", mosi.w_data, b.data);
                    check("w_last", mosi.w_last, b.last);
                end
                if (mosi.w_last) aw_seen = 1'b0;
            end
            if (mosi.aw_valid && aw_ready) begin
                check("aw_single", aw_seen, 0);
                aw_seen = 1'b1;
                if (exp_aw.size() == 0) begin
                    fail_evt("aw_extra");
                end else begin
                    aw_t a;
                    a = exp_aw.pop_front();
                    check("aw_addr", mosi.aw_addr, a.addr);
                    check("aw_len", mosi.aw_len, a.len);
                    check("aw_size", mosi.aw_size, 2);
                    check("aw_burst", mosi.aw_burst, 1);
                end
            end
            xfer_d = data_valid_i && data_ready_o;
            if (xfer_d) pay_cnt++;
            if (data_ready_o) dr_cnt++;
        end
    end

    // Payload source and W-channel backpressure
    initial begin
        data_valid_i = 1'b0;
        data_i       = '0;
        w_ready      = 1'b1;
        forever begin
            @(posedge clk_axi);
            #1;
            if (arst_axi) begin
                data_valid_i = 1'b0;
            end else begin
                if (xfer_d && feed_q.size() > 0) void'(feed_q.pop_front());
                data_valid_i = (feed_q.size() > 0) && (!gap_en || ($urandom_range(0, 2) != 0));
                data_i       = (feed_q.size() > 0) ? feed_q[0] : 32'h0;
                w_ready      = wr_toggle ? ~w_ready : 1'b1;
            end
        end
    end

    task automatic issue_cmd(input logic [1:0] vc, input logic [1:0] x, input logic [1:0] y,
                             input logic [7:0] len, input logic [31:0] addr, input int tag,
                             input bit sync);
        aw_t a;
        if (sync) begin
            @(posedge clk_axi);
            #1;
        end
        a.addr = addr;
        a.len  = len;
        exp_aw.push_back(a);
        exp_w.push_back('{data: {20'h0, x, y, len}, last: (len == 0)});
        for (int i = 0; i < int'(len); i++) begin
            logic [31:0] d;
            d = 32'hA0 + 32'(tag) * 32'h100 + 32'(i);
            feed_q.push_back(d);
            exp_w.push_back('{data: d, last: (i == int'(len) - 1)});
        end
        cmd_vc_i     = vc;
        cmd_x_dest_i = x;
        cmd_y_dest_i = y;
        cmd_len_i    = len;
        cmd_valid_i  = 1'b1;
    endtask

    task automatic accept_cmd();
        bit got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_axi);
            if (cmd_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_evt("cmd_accept_timeout");
        @(posedge clk_axi);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_w_done();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk_axi);
            if (exp_w.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail_evt("w_burst_timeout");
            exp_w.delete();
            feed_q.delete();
        end
        check("aw_issued", exp_aw.size(), 0);
    endtask

    task automatic respond_b(input logic [1:0] resp, input int delay);
        repeat (delay) @(posedge clk_axi);
        #1;
        b_valid = 1'b1;
        b_resp  = resp;
        @(negedge clk_axi);
        check("b_ready_in_b", mosi.b_ready, 1);
        @(posedge clk_axi);
        #1;
        b_valid = 1'b0;
        b_resp  = AXI_OKAY;
    endtask

    task automatic finish_pkt(input logic [1:0] resp, input int delay, input bit exp_done);
        wait_w_done();
        respond_b(resp, delay);
        @(negedge clk_axi);
        check("done_pulse", done_o, exp_done);
        check("err_pulse", err_o, !exp_done);
        @(negedge clk_axi);
        check("done_clear", done_o, 0);
        check("err_clear", err_o, 0);
        check("busy_clear", busy_o, 0);
    endtask

    task automatic run_vec(input vec_t v, input int tag);
        int pay0, dr0;
        pay0      = pay_cnt;
        dr0       = dr_cnt;
        gap_en    = v.gap;
        wr_toggle = v.toggle;
        if (v.aw_stall > 0) aw_ready = 1'b0;
        issue_cmd(v.vc, v.x, v.y, v.len, v.exp_addr, tag, 1'b1);
        accept_cmd();
        @(negedge clk_axi);
        check("busy_after_accept", busy_o, 1);
        if (v.aw_stall > 0) begin
            repeat (v.aw_stall) @(posedge clk_axi);
            #1;
            aw_ready = 1'b1;
        end
        finish_pkt(v.resp, v.b_delay, v.exp_done);
        check("payload_beats", pay_cnt - pay0, v.len);
        if (v.len == 0) check("no_data_ready", dr_cnt - dr0, 0);
        gap_en    = 1'b0;
        wr_toggle = 1'b0;
    endtask

    initial begin
        vec_t vecs[5];
        vec_t v6;
        int   first_err, err_cnt;
        bit   ok;

        vecs[0] = '{2'd1, 2'd2, 2'd1, 8'd3, AXI_OKAY,   0, 1'b0, 1'b0, 0, 32'h1008, 1'b1};
        vecs[1] = '{2'd0, 2'd1, 2'd3, 8'd0, AXI_OKAY,   2, 1'b0, 1'b0, 0, 32'h1000, 1'b1};
        vecs[2] = '{2'd2, 2'd3, 2'd0, 8'd4, AXI_OKAY,   1, 1'b1, 1'b1, 0, 32'h1010, 1'b1};
        vecs[3] = '{2'd2, 2'd0, 2'd2, 8'd2, AXI_OKAY,   3, 1'b0, 1'b1, 3, 32'h1010, 1'b1};
        vecs[4] = '{2'd0, 2'd3, 2'd3, 8'd6, 2'b11,      0, 1'b1, 1'b0, 1, 32'h1000, 1'b0};
        v6      = '{2'd2, 2'd1, 2'd2, 8'd1, AXI_OKAY,   1, 1'b0, 1'b0, 0, 32'h1010, 1'b1};

        n_tests = 0; n_fail = 0; pay_cnt = 0; dr_cnt = 0;
        gap_en = 1'b0; wr_toggle = 1'b0;
        arst_axi = 1'b1; cmd_valid_i = 1'b0; cmd_vc_i = '0; cmd_x_dest_i = '0;
        cmd_y_dest_i = '0; cmd_len_i = '0; aw_ready = 1'b1; b_valid = 1'b0; b_resp = AXI_OKAY;

        #12;
        check("rst_aw_valid", mosi.aw_valid, 0);
        check("rst_w_valid", mosi.w_valid, 0);
        check("rst_b_ready", mosi.b_ready, 0);
        check("rst_cmd_ready", cmd_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done_err", {done_o, err_o}, 0);
        @(posedge clk_axi);
        #1;
        arst_axi = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // SLVERR, with the next command already waiting during the err pulse
        issue_cmd(2'd1, 2'd1, 2'd1, 8'd1, 32'h1008, 7, 1'b1);
        accept_cmd();
        wait_w_done();
        respond_b(AXI_SLVERR, 0);
        issue_cmd(2'd0, 2'd2, 2'd2, 8'd2, 32'h1000, 8, 1'b0);
        @(negedge clk_axi);
        check("slverr_err", err_o, 1);
        check("slverr_done", done_o, 0);
        check("slverr_cmd_ready", cmd_ready_o, 1);
        @(posedge clk_axi);
        #1;
        cmd_valid_i = 1'b0;
        @(negedge clk_axi);
        check("b2b_busy", busy_o, 1);
        check("b2b_err_once", err_o, 0);
        finish_pkt(AXI_OKAY, 0, 1'b1);

        // B timeout, then a late response drained in IDLE
        issue_cmd(2'd1, 2'd0, 2'd1, 8'd1, 32'h1008, 9, 1'b1);
        accept_cmd();
        wait_w_done();
        first_err = -1;
        err_cnt   = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk_axi);
            if (err_o) begin
                err_cnt++;
                if (first_err < 0) first_err = k;
            end
            if (done_o) fail_evt("timeout_done");
        end
        check("timeout_cycle", first_err, 16);
        check("timeout_err_count", err_cnt, 1);
        check("timeout_idle", busy_o, 0);
        @(posedge clk_axi);
        #1;
        b_valid = 1'b1;
        @(negedge clk_axi);
        check("late_b_ready", mosi.b_ready, 1);
        @(posedge clk_axi);
        #1;
        b_valid = 1'b0;
        @(negedge clk_axi);
        check("late_b_silent", {done_o, err_o}, 0);
        check("late_b_drained", mosi.b_ready, 0);

        // Async reset after two W beats of a len=5 burst
        issue_cmd(2'd2, 2'd3, 2'd1, 8'd5, 32'h1010, 10, 1'b1);
        accept_cmd();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_axi);
            if (exp_w.size() <= 4) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_evt("rst_beat2_timeout");
        #1;
        arst_axi = 1'b1;
        #1;
        check("mid_rst_aw_valid", mosi.aw_valid, 0);
        check("mid_rst_w_valid", mosi.w_valid, 0);
        check("mid_rst_b_ready", mosi.b_ready, 0);
        check("mid_rst_ready", {cmd_ready_o, data_ready_o}, 0);
        check("mid_rst_status", {busy_o, done_o, err_o}, 0);
        exp_w.delete();
        exp_aw.delete();
        feed_q.delete();
        @(posedge clk_axi);
        @(posedge clk_axi);
        #1;
        arst_axi = 1'b0;
        run_vec(v6, 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
